imm_gen_pipe: RTL

Parametrised, pipelined immediate generator for the decode stage. It replaces the purely combinational immediate extension. It accepts 32-bit LEGv8 instructions over a valid/ready handshake and classifies the instruction format. It then produces a WORD-wide immediate with sign/zero extension, optional branch-offset scaling (<<2) and MOVZ/MOVK half-word positioning. A tag (typically the PC) travels alongside each instruction so downstream branch-target logic stays aligned.

---
 rtl/imm_gen_if.sv | 39 +++
 rtl/imm_gen_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_if.sv
// imm_gen_if: instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// "master" is the immediate generator's view; "slave" is the surrounding decode
// logic that offers instructions and consumes immediates.
// With IMMGEN_ILLEGAL_DET_EN defined, the bundle also carries out_illegal and
// illegal_seen.
interface imm_gen_if #(
    parameter int WORD  = 64,
    parameter int TAG_W = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WORD-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [TAG_W-1:0] out_tag;
`ifdef IMMGEN_ILLEGAL_DET_EN
    logic             out_illegal;
    logic             illegal_seen;
`endif

    modport master (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_tag
`ifdef IMMGEN_ILLEGAL_DET_EN
        , output out_illegal, illegal_seen
`endif
    );

    modport slave (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_tag
`ifdef IMMGEN_ILLEGAL_DET_EN
        , input out_illegal, illegal_seen
`endif
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage pipelined LEGv8 immediate generator.
// S1 captures the immediate-bearing instruction field, the tag and the format
// classification. S2 captures the WORD-wide extended immediate, the format and
// the tag. Both stages advance under one valid/ready handshake with no skid
// buffer, so in_ready is combinational from out_ready.
// Optional feature macro: IMMGEN_ILLEGAL_DET_EN adds out_illegal (registered
// with S2) and the sticky illegal_seen flag.
module imm_gen_pipe #(
    parameter int WORD         = 64,
    parameter int TAG_W        = 64,
    parameter int BRANCH_SCALE = 1,
    parameter int LOGIC_ZEXT   = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    imm_gen_if.master bus
);
    typedef enum logic [2:0] {
        FMT_NONE    = 3'd0,
        FMT_R_SHAMT = 3'd1,
        FMT_I       = 3'd2,
        FMT_D       = 3'd3,
        FMT_CB      = 3'd4,
        FMT_B       = 3'd5,
        FMT_IW      = 3'd6
    } fmt_t;

    // Format plus the two I-format sub-cases that change the extension.
    typedef struct packed {
        fmt_t fmt;
        logic logic_op;   // ANDI/ORRI/EORI/ANDIS
        logic zero;       // register-move alias: immediate forced to 0
    } cls_t;

    // Wide enough that a sign-extended offset shifted by 2 or a half-word at
    // position 48 is formed completely before truncation to WORD.
    localparam int XW = WORD + 64;

    // LEGv8 opcode patterns on instr[31:21]
    localparam logic [10:0] OP_B     = 11'b000101?????;
    localparam logic [10:0] OP_BL    = 11'b100101?????;
    localparam logic [10:0] OP_CBZ   = 11'b10110100???;
    localparam logic [10:0] OP_CBNZ  = 11'b10110101???;
    localparam logic [10:0] OP_BCOND = 11'b01010100???;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_LSL   = 11'b11010011011;
    localparam logic [10:0] OP_LSR   = 11'b11010011010;
    localparam logic [10:0] OP_MOVZ  = 11'b110100101??;
    localparam logic [10:0] OP_MOVK  = 11'b111100101??;
    localparam logic [10:0] OP_ADDI  = 11'b1001000100?;
    localparam logic [10:0] OP_ADDIS = 11'b1011000100?;
    localparam logic [10:0] OP_SUBI  = 11'b1101000100?;
    localparam logic [10:0] OP_SUBIS = 11'b1111000100?;
    localparam logic [10:0] OP_ANDI  = 11'b1001001000?;
    localparam logic [10:0] OP_ORRI  = 11'b1011001000?;
    localparam logic [10:0] OP_EORI  = 11'b1101001000?;
    localparam logic [10:0] OP_ANDIS = 11'b1111001000?;
    localparam logic [10:0] OP_MOV   = 11'b10101010000;  // ORR Rd, XZR, Rm

    function automatic cls_t classify(input logic [10:0] op);
        cls_t c;
        c = '{fmt: FMT_NONE, logic_op: 1'b0, zero: 1'b0};
        casez (op)
            OP_B, OP_BL:                       c.fmt = FMT_B;
            OP_CBZ, OP_CBNZ, OP_BCOND:         c.fmt = FMT_CB;
            OP_LDUR, OP_STUR:                  c.fmt = FMT_D;
            OP_LSL, OP_LSR:                    c.fmt = FMT_R_SHAMT;
            OP_MOVZ, OP_MOVK:                  c.fmt = FMT_IW;
            OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS: c.fmt = FMT_I;
            OP_ANDI, OP_ORRI, OP_EORI, OP_ANDIS: begin
                c.fmt      = FMT_I;
                c.logic_op = 1'b1;
            end
            OP_MOV: begin
                c.fmt  = FMT_I;
                c.zero = 1'b1;
            end
            default:                           c.fmt = FMT_NONE;
        endcase
        return c;
    endfunction

    // Extension, branch scaling and half-word placement, done at XW bits so
    // the shifts happen before truncation.
    function automatic logic [WORD-1:0] extend(input logic [25:0] ins, input cls_t c);
        logic [XW-1:0] w;
        w = '0;
        case (c.fmt)
            FMT_R_SHAMT: w = XW'(ins[15:10]);
            FMT_I: begin
                if (c.zero)
                    w = '0;
                else if (c.logic_op && (LOGIC_ZEXT != 0))
                    w = XW'(ins[21:10]);
                else
                    w = {{(XW-12){ins[21]}}, ins[21:10]};
            end
            FMT_D:  w = {{(XW-9){ins[20]}}, ins[20:12]};
            FMT_CB: w = {{(XW-19){ins[23]}}, ins[23:5]};
            FMT_B:  w = {{(XW-26){ins[25]}}, ins[25:0]};
            FMT_IW: w = XW'(ins[20:5]) << {ins[22:21], 4'b0000};
            default: w = '0;
        endcase
        if ((BRANCH_SCALE != 0) && ((c.fmt == FMT_CB) || (c.fmt == FMT_B)))
            w = w << 2;
        return w[WORD-1:0];
    endfunction

`ifdef IMMGEN_ILLEGAL_DET_EN
    // Unknown opcode, or a MOVZ/MOVK half-word that lands partly or fully
    // above WORD.
    function automatic logic is_illegal(input logic [25:0] ins, input cls_t c);
        return (c.fmt == FMT_NONE) ||
               ((c.fmt == FMT_IW) && ((16 * int'(ins[22:21]) + 16) > WORD));
    endfunction
`endif

    logic             vld_p1, vld_p2;
    logic [25:0]      instr_p1;
    logic [TAG_W-1:0] tag_p1, tag_p2;
    cls_t             cls_p1;
    logic [WORD-1:0]  imm_p2;
    fmt_t             fmt_p2;
    logic             s1_adv, s2_adv;

    assign s2_adv       = !vld_p2 || bus.out_ready;
    assign s1_adv       = !vld_p1 || s2_adv;
    assign bus.in_ready = rst_n && s1_adv;

    // Stage valids; flush empties the pipe and drops any same-cycle offer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (s1_adv) vld_p1 <= bus.in_valid;
            if (s2_adv) vld_p2 <= vld_p1;
        end
    end

    // ---- S1: capture instruction field, tag and classification ----
    always_ff @(posedge clk) begin
        if (s1_adv) begin
            instr_p1 <= bus.in_instr[25:0];
            tag_p1   <= bus.in_tag;
            cls_p1   <= classify(bus.in_instr[31:21]);
        end
    end

    // ---- S2: capture extended immediate, format and tag; cleared on reset ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_p2 <= '0;
            fmt_p2 <= FMT_NONE;
            tag_p2 <= '0;
        end else if (s2_adv) begin
            imm_p2 <= extend(instr_p1, cls_p1);
            fmt_p2 <= cls_p1.fmt;
            tag_p2 <= tag_p1;
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_imm   = imm_p2;
    assign bus.out_fmt   = fmt_p2;
    assign bus.out_tag   = tag_p2;

`ifdef IMMGEN_ILLEGAL_DET_EN
    logic ill_p2;
    logic seen;

    // Illegal flag rides with S2; the sticky flag latches on any illegal
    // result entering S2 and clears only on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_p2 <= 1'b0;
            seen   <= 1'b0;
        end else begin
            if (s2_adv)
                ill_p2 <= vld_p1 && is_illegal(instr_p1, cls_p1);
            if (!flush && s2_adv && vld_p1 && is_illegal(instr_p1, cls_p1))
                seen <= 1'b1;
        end
    end

    assign bus.out_illegal  = ill_p2 && vld_p2;
    assign bus.illegal_seen = seen;
`endif
endmodule
